// File: rtl/sensor_alarm.sv
// rtl/sensor_alarm.sv - debounced hysteresis alarm on a moving-average sample stream
// Optional peak-hold register enabled by defining SENSOR_ALARM_PEAK_HOLD_EN.
module sensor_alarm #(
    parameter logic [7:0]  HI_TH    = 8'd200,
    parameter logic [7:0]  LO_TH    = 8'd150,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_mov_avg,
    input  logic       i_avg_valid,
    input  logic       i_clear_peak,
    output logic       o_alarm,
    output logic       o_alarm_set,
    output logic       o_alarm_clr,
    output logic [7:0] o_event_count,
    output logic [7:0] o_peak,
    output logic [1:0] o_fsm_state
);

    typedef enum logic [1:0] {
        S_NORMAL  = 2'd0,
        S_RISING  = 2'd1,
        S_ALARM   = 2'd2,
        S_FALLING = 2'd3
    } state_t;

    localparam logic [3:0] DEB = DEBOUNCE[3:0];

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic [3:0] w_cnt_inc;
    logic       w_hi;
    logic       w_lo;
    logic       w_set;
    logic       w_clr;
    logic       r_alarm;
    logic       r_alarm_set;
    logic       r_alarm_clr;
    logic [7:0] r_event_count;

    assign w_hi      = (i_mov_avg >= HI_TH);
    assign w_lo      = (i_mov_avg <= LO_TH);
    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_set        = 1'b0;
        w_clr        = 1'b0;
        if (i_avg_valid) begin
            case (r_state)
                S_NORMAL: begin
                    if (w_hi) begin
                        w_next_state = S_RISING;
                        w_next_cnt   = 4'd1;
                    end else begin
                        w_next_cnt   = 4'd0;
                    end
                end
                S_RISING: begin
                    if (!w_hi) begin
                        w_next_state = S_NORMAL;
                        w_next_cnt   = 4'd0;
                    end else if (w_cnt_inc == DEB) begin
                        w_next_state = S_ALARM;
                        w_next_cnt   = 4'd0;
                        w_set        = 1'b1;
                    end else begin
                        w_next_cnt   = w_cnt_inc;
                    end
                end
                S_ALARM: begin
                    if (w_lo) begin
                        w_next_state = S_FALLING;
                        w_next_cnt   = 4'd1;
                    end else begin
                        w_next_cnt   = 4'd0;
                    end
                end
                S_FALLING: begin
                    // A sample back above LO_TH aborts the clear silently.
                    if (!w_lo) begin
                        w_next_state = S_ALARM;
                        w_next_cnt   = 4'd0;
                    end else if (w_cnt_inc == DEB) begin
                        w_next_state = S_NORMAL;
                        w_next_cnt   = 4'd0;
                        w_clr        = 1'b1;
                    end else begin
                        w_next_cnt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_next_state = S_NORMAL;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_NORMAL;
            r_cnt         <= 4'd0;
            r_alarm       <= 1'b0;
            r_alarm_set   <= 1'b0;
            r_alarm_clr   <= 1'b0;
            r_event_count <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_alarm     <= (w_next_state == S_ALARM) || (w_next_state == S_FALLING);
            r_alarm_set <= w_set;
            r_alarm_clr <= w_clr;
            if (w_set && (r_event_count != 8'hFF)) begin
                r_event_count <= r_event_count + 8'd1;
            end
        end
    end

`ifdef SENSOR_ALARM_PEAK_HOLD_EN
    logic [7:0] r_peak;

    // Clear with a coincident sample restarts the peak at that sample.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_peak <= 8'd0;
        end else if (i_clear_peak) begin
            r_peak <= i_avg_valid ? i_mov_avg : 8'd0;
        end else if (i_avg_valid && (i_mov_avg > r_peak)) begin
            r_peak <= i_mov_avg;
        end
    end

    assign o_peak = r_peak;
`else
    logic w_unused_clear_peak;
    assign w_unused_clear_peak = i_clear_peak;
    assign o_peak              = 8'd0;
`endif

    assign o_alarm       = r_alarm;
    assign o_alarm_set   = r_alarm_set;
    assign o_alarm_clr   = r_alarm_clr;
    assign o_event_count = r_event_count;
    assign o_fsm_state   = r_state;

endmodule

// File: tb/tb_sensor_alarm.sv
// tb/tb_sensor_alarm.sv - scoreboard bench for sensor_alarm (HI_TH=200, LO_TH=150, DEBOUNCE=3)
module tb_sensor_alarm;

`ifdef SENSOR_ALARM_PEAK_HOLD_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mov_avg;
    logic       avg_valid;
    logic       clear_peak;
    logic       alarm;
    logic       alarm_set;
    logic       alarm_clr;
    logic [7:0] event_count;
    logic [7:0] peak;
    logic [1:0] fsm_state;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_evt  = 8'd0;
    logic [7:0] m_peak = 8'd0;

    typedef struct {
        string       tag;
        logic [20:0] exp;
    } sb_t;
    sb_t sbq[$];

    sensor_alarm #(.HI_TH(8'd200), .LO_TH(8'd150), .DEBOUNCE(3)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_mov_avg     (mov_avg),
        .i_avg_valid   (avg_valid),
        .i_clear_peak  (clear_peak),
        .o_alarm       (alarm),
        .o_alarm_set   (alarm_set),
        .o_alarm_clr   (alarm_clr),
        .o_event_count (event_count),
        .o_peak        (peak),
        .o_fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    // Packed layout: {fsm[20:19], alarm, set, clr, event_count[15:8], peak[7:0]}
    task automatic step(input string tag, input bit rst, input bit vld, input logic [7:0] smp,
                        input bit clr_pk, input logic [1:0] e_fsm, input bit e_alarm,
                        input bit e_set, input bit e_clr);
        sb_t        item;
        sb_t        got;
        logic [20:0] obs;
        @(negedge clk);
        rst_n      = ~rst;
        avg_valid  = vld;
        mov_avg    = smp;
        clear_peak = clr_pk;
        if (rst) begin
            m_evt  = 8'd0;
            m_peak = 8'd0;
        end else begin
            if (e_set && (m_evt != 8'hFF)) m_evt = m_evt + 8'd1;
            if (clr_pk) m_peak = vld ? smp : 8'd0;
            else if (vld && (smp > m_peak)) m_peak = smp;
        end
        item.tag = tag;
        item.exp = {e_fsm, e_alarm, e_set, e_clr, m_evt, (PEAK_ON ? m_peak : 8'd0)};
        sbq.push_back(item);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        obs = {fsm_state, alarm, alarm_set, alarm_clr, event_count, peak};
        checks++;
        assert (obs === got.exp) else begin
            errors++;
            $error("FAIL %s: observed fsm/alarm/set/clr/evt/peak=%0d/%0b/%0b/%0b/%0d/%0d expected %0d/%0b/%0b/%0b/%0d/%0d",
                   got.tag, obs[20:19], obs[18], obs[17], obs[16], obs[15:8], obs[7:0],
                   got.exp[20:19], got.exp[18], got.exp[17], got.exp[16], got.exp[15:8], got.exp[7:0]);
        end
    endtask

    task automatic check_peak(input string tag, input logic [7:0] e_on);
        logic [7:0] e;
        e = PEAK_ON ? e_on : 8'd0;
        checks++;
        assert (peak === e) else begin
            errors++;
            $error("FAIL %s: observed peak=%0d expected %0d", tag, peak, e);
        end
    endtask

    initial begin
        rst_n = 1'b0; mov_avg = 8'd0; avg_valid = 1'b0; clear_peak = 1'b0;

        step("reset0", 1, 0, 8'd0, 0, 2'd0, 0, 0, 0);
        step("reset1", 1, 1, 8'd210, 1, 2'd0, 0, 0, 0);

        // Three qualifying samples raise the alarm
        step("rise1", 0, 1, 8'd210, 0, 2'd1, 0, 0, 0);
        step("rise2", 0, 1, 8'd210, 0, 2'd1, 0, 0, 0);
        step("rise3", 0, 1, 8'd210, 0, 2'd2, 1, 1, 0);
        step("hold_alarm", 0, 1, 8'd180, 0, 2'd2, 1, 0, 0);

        // Fall aborted by 160, then a clean clear
        step("fall1", 0, 1, 8'd140, 0, 2'd3, 1, 0, 0);
        step("fall_abort", 0, 1, 8'd160, 0, 2'd2, 1, 0, 0);
        step("fall_a", 0, 1, 8'd140, 0, 2'd3, 1, 0, 0);
        step("fall_b", 0, 1, 8'd140, 0, 2'd3, 1, 0, 0);
        step("fall_c", 0, 1, 8'd140, 0, 2'd0, 0, 0, 1);
        step("after_clr", 0, 1, 8'd100, 0, 2'd0, 0, 0, 0);

        // Broken rise returns to NORMAL without a set
        step("reset2", 1, 0, 8'd0, 0, 2'd0, 0, 0, 0);
        step("brk1", 0, 1, 8'd210, 0, 2'd1, 0, 0, 0);
        step("brk2", 0, 1, 8'd210, 0, 2'd1, 0, 0, 0);
        step("brk199", 0, 1, 8'd199, 0, 2'd0, 0, 0, 0);

        // Invalid cycles interleaved are ignored
        step("iv1", 0, 1, 8'd210, 0, 2'd1, 0, 0, 0);
        step("iv_x1", 0, 0, 8'd0, 0, 2'd1, 0, 0, 0);
        step("iv2", 0, 1, 8'd210, 0, 2'd1, 0, 0, 0);
        step("iv_x2", 0, 0, 8'd0, 0, 2'd1, 0, 0, 0);
        step("iv3", 0, 1, 8'd210, 0, 2'd2, 1, 1, 0);
        step("iv_hold", 0, 0, 8'd0, 0, 2'd2, 1, 0, 0);

        // Threshold boundaries: 151 is in the band, 150 qualifies for clear
        step("b151", 0, 1, 8'd151, 0, 2'd2, 1, 0, 0);
        step("b150a", 0, 1, 8'd150, 0, 2'd3, 1, 0, 0);
        step("b151f", 0, 1, 8'd151, 0, 2'd2, 1, 0, 0);
        step("b150b", 0, 1, 8'd150, 0, 2'd3, 1, 0, 0);
        step("b150c", 0, 1, 8'd150, 0, 2'd3, 1, 0, 0);
        step("b150d", 0, 1, 8'd150, 0, 2'd0, 0, 0, 1);
        step("b199", 0, 1, 8'd199, 0, 2'd0, 0, 0, 0);
        step("b200a", 0, 1, 8'd200, 0, 2'd1, 0, 0, 0);
        step("b200b", 0, 1, 8'd200, 0, 2'd1, 0, 0, 0);
        step("b200c", 0, 1, 8'd200, 0, 2'd2, 1, 1, 0);

        // Reset in ALARM and mid-debounce yields no clear pulse
        step("fall_pre", 0, 1, 8'd100, 0, 2'd3, 1, 0, 0);
        step("rst_alarm", 1, 1, 8'd100, 0, 2'd0, 0, 0, 0);

        // Saturation of event_count
        for (int n = 0; n < 256; n++) begin
            step("sat_r1", 0, 1, 8'd230, 0, 2'd1, 0, 0, 0);
            step("sat_r2", 0, 1, 8'd230, 0, 2'd1, 0, 0, 0);
            step("sat_r3", 0, 1, 8'd230, 0, 2'd2, 1, 1, 0);
            step("sat_f1", 0, 1, 8'd20, 0, 2'd3, 1, 0, 0);
            step("sat_f2", 0, 1, 8'd20, 0, 2'd3, 1, 0, 0);
            step("sat_f3", 0, 1, 8'd20, 0, 2'd0, 0, 0, 1);
        end
        checks++;
        assert (event_count === 8'd255) else begin
            errors++;
            $error("FAIL sat_final: observed event_count=%0d expected 255", event_count);
        end
        step("mid_rise", 0, 1, 8'd210, 0, 2'd1, 0, 0, 0);
        step("rst_mid_rise", 1, 1, 8'd210, 1, 2'd0, 0, 0, 0);

        // Peak hold
        step("pk12", 0, 1, 8'd12, 0, 2'd0, 0, 0, 0);
        step("pk230", 0, 1, 8'd230, 0, 2'd1, 0, 0, 0);
        step("pk90", 0, 1, 8'd90, 0, 2'd0, 0, 0, 0);
        check_peak("peak_max", 8'd230);
        step("pk_idle", 0, 0, 8'd250, 0, 2'd0, 0, 0, 0);
        check_peak("peak_hold_invalid", 8'd230);
        step("pk_clr40", 0, 1, 8'd40, 1, 2'd0, 0, 0, 0);
        check_peak("peak_clr_sample", 8'd40);
        step("pk_clr0", 0, 0, 8'd77, 1, 2'd0, 0, 0, 0);
        check_peak("peak_clr_alone", 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
